// File: rtl/seq_exec_unit_if.sv
// seq_exec_unit_if: request/response channel between the issue logic (master) and seq_exec_unit (slave)
// req_*  : one operation (operands, invert controls, ALU op, shift controls) on a valid/ready handshake
// resp_* : result with zero/overflow flags on a valid/ready handshake
interface seq_exec_unit_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_shift;
  logic             req_invertA;
  logic             req_invertB;
  logic [1:0]       req_operation;
  logic [WIDTH-1:0] req_src1;
  logic [WIDTH-1:0] req_src2;
  logic             req_leftRight;
  logic [4:0]       req_shamt;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_overflow;
  modport master (
    output req_valid, req_is_shift, req_invertA, req_invertB, req_operation,
           req_src1, req_src2, req_leftRight, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_overflow
  );
  modport slave (
    input  req_valid, req_is_shift, req_invertA, req_invertB, req_operation,
           req_src1, req_src2, req_leftRight, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_overflow
  );
endinterface

// File: rtl/seq_exec_unit.sv
// seq_exec_unit: multi-cycle ALU (one execute cycle) and 1-bit-per-cycle shifter behind a valid/ready interface
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, aborts any in-flight operation
// bus   : seq_exec_unit_if slave port (req_* request channel, resp_* response channel)
module seq_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_exec_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
  state_t           state, state_n;
  logic             alive, inv_a, inv_b, left, accept, ovf, alu_ovf, last_shift;
  logic             zero, overflow;
  logic [1:0]       op;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] src1, work, a_op, b_op, sum, alu_res, sh_res, result;
  // alive keeps req_ready low during reset and for the edge that releases it
  assign bus.req_ready     = alive && state == IDLE;
  assign bus.resp_valid    = state == RESP;
  assign bus.resp_result   = result;
  assign bus.resp_zero     = zero;
  assign bus.resp_overflow = overflow;
  assign accept            = bus.req_valid && bus.req_ready;
  // the final shift and the move to RESP share an edge; shamt=0 still spends one cycle here
  assign last_shift        = cnt <= 5'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (bus.req_is_shift ? SHIFT : EXEC) : IDLE;
      EXEC:    state_n = RESP;
      SHIFT:   state_n = last_shift ? RESP : SHIFT;
      default: state_n = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    a_op    = inv_a ? ~src1 : src1;
    b_op    = inv_b ? ~work : work;
    sum     = a_op + b_op + {{(WIDTH-1){1'b0}}, inv_b};
    ovf     = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
    alu_res = op == 2'b00 ? a_op & b_op :
              op == 2'b01 ? a_op | b_op :
              op == 2'b10 ? sum : {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
    alu_ovf = op[1] && ovf;
    sh_res  = cnt == 5'd0 ? work : left ? work << 1 : work >> 1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alive    <= 1'b0;
      inv_a    <= 1'b0;
      inv_b    <= 1'b0;
      left     <= 1'b0;
      op       <= 2'b00;
      src1     <= '0;
      work     <= '0;
      cnt      <= 5'd0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        inv_a <= bus.req_invertA;
        inv_b <= bus.req_invertB;
        left  <= bus.req_leftRight;
        op    <= bus.req_operation;
        src1  <= bus.req_src1;
        work  <= bus.req_src2;
        cnt   <= bus.req_shamt;
      end
      if (state == EXEC) begin
        result   <= alu_res;
        zero     <= alu_res == '0;
        overflow <= alu_ovf;
      end
      if (state == SHIFT) begin
        work <= sh_res;
        cnt  <= cnt == 5'd0 ? 5'd0 : cnt - 5'd1;
        if (last_shift) begin
          result   <= sh_res;
          zero     <= sh_res == '0;
          overflow <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_seq_exec_unit.sv
// tb_seq_exec_unit: directed vectors with literal expectations plus a transaction-level reference model
module tb_seq_exec_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  seq_exec_unit_if #(.WIDTH(32)) bus();
  seq_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [31:0] r;
    logic        o;
  } res_t;
  typedef struct packed {
    logic        sh, ia, ib;
    logic [1:0]  op;
    logic [31:0] s1, s2;
    logic        lr;
    logic [4:0]  amt;
    logic [31:0] er;
    logic        eo, ez;
    int          lat;
    int          hold;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // reference: signed arithmetic on mathematical integers, shifts as whole-word shifts
  function automatic res_t model(input logic sh, ia, ib, input logic [1:0] op,
                                 input logic [31:0] s1, s2, input logic lr, input logic [4:0] amt);
    logic [31:0] a, b;
    longint      t;
    logic        o;
    res_t        m;
    a = ia ? ~s1 : s1;
    b = ib ? ~s2 : s2;
    t = longint'($signed(a)) + longint'($signed(b)) + longint'(ib);
    o = t > 64'sd2147483647 || t < -64'sd2147483648;
    if (sh) m = '{r: lr ? s2 << amt : s2 >> amt, o: 1'b0};
    else if (op == 2'b00) m = '{r: a & b, o: 1'b0};
    else if (op == 2'b01) m = '{r: a | b, o: 1'b0};
    else if (op == 2'b10) m = '{r: t[31:0], o: o};
    else m = '{r: {31'b0, t < 0}, o: o};
    return m;
  endfunction
  // transaction tracker: edges remaining until the response must appear
  logic        m_up, m_pend;
  int          m_left;
  res_t        m_exp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_up   <= 1'b0;
      m_pend <= 1'b0;
      m_left <= 0;
    end else begin
      m_up <= 1'b1;
      if (m_pend && m_left == 0) begin
        if (bus.resp_ready) m_pend <= 1'b0;
      end else if (m_pend) m_left <= m_left - 1;
      else if (m_up && bus.req_valid) begin
        m_pend <= 1'b1;
        m_left <= bus.req_is_shift ? (bus.req_shamt == 5'd0 ? 1 : int'(bus.req_shamt)) : 1;
        m_exp  <= model(bus.req_is_shift, bus.req_invertA, bus.req_invertB, bus.req_operation,
                        bus.req_src1, bus.req_src2, bus.req_leftRight, bus.req_shamt);
      end
    end
  always @(negedge clk) begin
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, m_up && !m_pend});
    chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, m_pend && m_left == 0});
    if (m_pend && m_left == 0) begin
      chk("model_result", bus.resp_result, m_exp.r);
      chk("model_overflow", {31'b0, bus.resp_overflow}, {31'b0, m_exp.o});
      chk("model_zero", {31'b0, bus.resp_zero}, {31'b0, m_exp.r == 32'd0});
    end
  end
  // lat counts the accept edge as edge 1
  localparam int NV = 11;
  vec_t vecs [NV] = '{
    '{1'b0, 1'b0, 1'b0, 2'b10, 32'h7FFFFFFF, 32'h00000001, 1'b0, 5'd0,  32'h80000000, 1'b1, 1'b0, 2,  0},
    '{1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd0,  32'h00000001, 1'b0, 1'b0, 2,  5},
    '{1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 2,  0},
    '{1'b0, 1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h00000000, 1'b0, 1'b1, 2,  1},
    '{1'b1, 1'b0, 1'b0, 2'b00, 32'h00000000, 32'h00000001, 1'b1, 5'd31, 32'h80000000, 1'b0, 1'b0, 32, 0},
    '{1'b1, 1'b1, 1'b1, 2'b10, 32'hFFFFFFFF, 32'hF0000000, 1'b0, 5'd4,  32'h0F000000, 1'b0, 1'b0, 5,  2},
    '{1'b1, 1'b0, 1'b0, 2'b10, 32'h7FFFFFFF, 32'h12345678, 1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0, 2,  0},
    '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0F0F0000, 32'h000000F0, 1'b0, 5'd0,  32'h0F0F00F0, 1'b0, 1'b0, 2,  0},
    '{1'b0, 1'b0, 1'b0, 2'b10, 32'h80000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b1, 2,  0},
    '{1'b0, 1'b0, 1'b1, 2'b11, 32'h00000005, 32'h00000007, 1'b0, 5'd0,  32'h00000001, 1'b0, 1'b0, 2,  0},
    '{1'b1, 1'b0, 1'b0, 2'b00, 32'h00000000, 32'h00000001, 1'b0, 5'd1,  32'h00000000, 1'b0, 1'b1, 2,  0}
  };
  task automatic send(input vec_t v);
    @(negedge clk);
    bus.req_is_shift  = v.sh;
    bus.req_invertA   = v.ia;
    bus.req_invertB   = v.ib;
    bus.req_operation = v.op;
    bus.req_src1      = v.s1;
    bus.req_src2      = v.s2;
    bus.req_leftRight = v.lr;
    bus.req_shamt     = v.amt;
    bus.req_valid     = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_src1 = ~v.s1;
    bus.req_src2 = ~v.s2;
    bus.req_shamt = ~v.amt;
  endtask
  task automatic run(input vec_t v);
    int n;
    send(v);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.resp_valid && n < 100);
    chk("latency", n + 1, v.lat);
    chk("result", bus.resp_result, v.er);
    chk("overflow", {31'b0, bus.resp_overflow}, {31'b0, v.eo});
    chk("zero", {31'b0, bus.resp_zero}, {31'b0, v.ez});
    repeat (v.hold) @(negedge clk);
    @(negedge clk) bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("valid_drop", {31'b0, bus.resp_valid}, 32'd0);
    chk("ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b1;
    bus.req_valid = 1'b1;
    bus.resp_ready = 1'b0;
    bus.req_is_shift = 1'b0;
    bus.req_invertA = 1'b0;
    bus.req_invertB = 1'b0;
    bus.req_operation = 2'b00;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.req_leftRight = 1'b0;
    bus.req_shamt = 5'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_result", bus.resp_result, 32'd0);
    chk("rst_flags", {30'b0, bus.resp_zero, bus.resp_overflow}, 32'd0);
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_ready", {31'b0, bus.req_ready}, 32'd1);
    for (int i = 0; i < NV; i++) run(vecs[i]);
    send('{1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0000FFFF, 1'b1, 5'd20, 32'h0, 1'b0, 1'b0, 0, 0});
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_result", bus.resp_result, 32'd0);
    #2 rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1 chk("abort_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
    chk("abort_idle", {31'b0, bus.req_ready}, 32'd1);
    run(vecs[0]);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
